keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
- Upstream front end for the phone code checker. Drives a 4x4 membrane keypad matrix one column at a time, detects a pressed key, and debounces both press and release.
- Presents the result downstream as a level `Keypressed` and an 8-bit ASCII `button`.
- Downstream captures `button` on the falling edge of `Keypressed`, so `button` stays stable through and after release.

Parameters:
- `SCAN_DIV`, default 4: clock cycles each column stays driven (settle time). Legal range ≥2.
- `DEBOUNCE_CNT`, default 8: consecutive matching samples required to accept a press or a release. Legal range ≥1.

Ports:
- `clk`  input  1  system clock, all logic on rising edge.
- `rst`  input  1  asynchronous, active-low reset.
- `row_in`  input  4  keypad rows, active-low (pulled up externally), assumed already synchronised.
- `col_out`  output  4  column drive, active-low, exactly one bit low at all times.
- `Keypressed`  output  1  high while a debounced key is held.
- `button`  output  8  ASCII code of the last accepted key.

Behaviour:
- Reset (`rst`=0, asynchronous) values:
  - `col_out`=4'b1110 (column 0), `Keypressed`=0, `button`=8'h20 (ASCII space).
  - Slot counter 0, debounce counter 0, state SCAN.
  - Reset mid-press aborts everything; no press is reported for a key already held when reset releases until the normal debounce completes.
- Slot timing:
  - A slot counter counts 0..`SCAN_DIV`-1.
  - `row_in` is sampled only on the edge where the slot counter equals `SCAN_DIV`-1 (the "sample edge").
- Key map, row r (`row_in` bit r) / column c (`col_out` bit c low):
  - r0: '1' '2' '3' 'A'
  - r1: '4' '5' '6' 'B'
  - r2: '7' '8' '9' 'C'
  - r3: '*' '0' '#' 'D'
- States:
  - SCAN: on each sample edge:
    - If `row_in`==4'hF, rotate the column (1110→1101→1011→0111→1110).
    - If exactly one row bit is low, latch row/column, hold the column, debounce count=1, go to PRESS_DB.
    - If two or more row bits are low, treat as bounce and rotate as normal.
  - PRESS_DB: column held. On each sample edge:
    - Same single row low: count+1. When the count reaches `DEBOUNCE_CNT`, on that same edge set `Keypressed`=1, load `button` with the mapped ASCII code, count=0, go to HELD.
    - Any other value: count=0, return to SCAN and rotate to the next column on that edge.
    - With `DEBOUNCE_CNT`=1, acceptance happens on the detection edge itself.
  - HELD: column held, `Keypressed`=1. On each sample edge:
    - `row_in`==4'hF: count+1; otherwise count=0.
    - When the count reaches `DEBOUNCE_CNT`: `Keypressed`=0, count=0, go to SCAN (column rotates on the next sample edge).
    - A second key pressed while held is ignored.
- `button` changes only on press acceptance and holds its value after release, through idle, until the next accepted press.
- Latency: `Keypressed` rises exactly `SCAN_DIV`×(`DEBOUNCE_CNT`-1) cycles after the detection sample edge. It falls `SCAN_DIV`×`DEBOUNCE_CNT` cycles after the first all-high sample, for a clean release.
- Counters saturate at their terminal values. There is no wrap-around while a state is held.

Optional Feature:
- Macro: `KEYPAD_MULTIKEY_ERR_EN`.
- Defined:
  - Adds output port `multi_err` (1 bit, reset 0).
  - `multi_err` pulses high for exactly one cycle on any sample edge, in any state, where two or more row bits are low.
  - State transitions are unchanged.
- Undefined: the port and its logic are absent; multi-row samples are handled silently as above.

Test Plan:
- Use `SCAN_DIV`=4, `DEBOUNCE_CNT`=3 unless noted.
- Reset then idle 40 cycles, `row_in`=4'hF → `col_out` cycles 1110,1101,1011,0111 every 4 clocks; `Keypressed`=0; `button`=8'h20.
- Press '5' cleanly (drive `row_in`[1] low whenever `col_out`[1]=0) → column freezes at 1101; `Keypressed` rises 8 cycles after the detection edge; `button`=8'h35.
- Release '5' → `Keypressed` falls 12 cycles after the first all-high sample; `button` stays 8'h35; scanning resumes.
- Bounce: `row_in`[0] low for 1 sample then high during column 3 → no `Keypressed`, scanning continues. Then press '#' cleanly → `button`=8'h23.
- Two rows low on column 0 → no press accepted. With `KEYPAD_MULTIKEY_ERR_EN` defined, one-cycle `multi_err` pulses on each such sample edge.
- Assert `rst`=0 while HELD on 'D' → `Keypressed`=0, `button`=8'h20, `col_out`=1110 immediately. Release reset with the key still held → 'D' is re-accepted only after the full debounce.

Source files
------------

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner with press/release debounce and ASCII key output.
// Optional KEYPAD_MULTIKEY_ERR_EN adds a one-cycle multi_err pulse on multi-row samples.
module keypad_scanner #(
    parameter int unsigned SCAN_DIV     = 4,
    parameter int unsigned DEBOUNCE_CNT = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       Keypressed,
`ifdef KEYPAD_MULTIKEY_ERR_EN
    output logic       multi_err,
`endif
    output logic [7:0] button
);

    localparam int unsigned SW  = $clog2(SCAN_DIV);
    localparam int unsigned DBW = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [SW-1:0]  SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [DBW-1:0] DB_MAX    = DBW'(DEBOUNCE_CNT);
    localparam logic           DB_ONE    = (DEBOUNCE_CNT == 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_PRESS_DB = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;

    localparam logic [7:0] ASCII_SPACE = 8'h20;

    logic [1:0]     state_q, state_d;
    logic [SW-1:0]  slot_q, slot_d;
    logic [1:0]     col_q, col_d;
    logic [DBW-1:0] cnt_q, cnt_d;
    logic [3:0]     row_q, row_d;
    logic           pressed_q, pressed_d;
    logic [7:0]     button_q, button_d;

    logic           sample;
    logic           row_idle;
    logic           row_single;
    logic           row_multi;
    logic [DBW-1:0] cnt_inc;

    // Index of the single low row bit; only meaningful when the pattern is one-hot low.
    function automatic logic [1:0] row_index(input logic [3:0] rows);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!rows[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

    function automatic logic [7:0] key_ascii(input logic [1:0] r, input logic [1:0] c);
        logic [7:0] code;
        unique case ({r, c})
            4'h0:    code = 8'h31;  // '1'
            4'h1:    code = 8'h32;  // '2'
            4'h2:    code = 8'h33;  // '3'
            4'h3:    code = 8'h41;  // 'A'
            4'h4:    code = 8'h34;  // '4'
            4'h5:    code = 8'h35;  // '5'
            4'h6:    code = 8'h36;  // '6'
            4'h7:    code = 8'h42;  // 'B'
            4'h8:    code = 8'h37;  // '7'
            4'h9:    code = 8'h38;  // '8'
            4'hA:    code = 8'h39;  // '9'
            4'hB:    code = 8'h43;  // 'C'
            4'hC:    code = 8'h2A;  // '*'
            4'hD:    code = 8'h30;  // '0'
            4'hE:    code = 8'h23;  // '#'
            default: code = 8'h44;  // 'D'
        endcase
        return code;
    endfunction

    assign sample     = (slot_q == SLOT_LAST);
    assign row_idle   = (row_in == 4'hF);
    assign row_single = $onehot(~row_in);
    assign row_multi  = !row_idle && !row_single;
    assign cnt_inc    = cnt_q + 1'b1;

    assign slot_d = sample ? '0 : slot_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        cnt_d     = cnt_q;
        row_d     = row_q;
        pressed_d = pressed_q;
        button_d  = button_q;

        if (sample) begin
            case (state_q)
                ST_SCAN: begin
                    if (row_single) begin
                        row_d = row_in;
                        if (DB_ONE) begin
                            pressed_d = 1'b1;
                            button_d  = key_ascii(row_index(row_in), col_q);
                            cnt_d     = '0;
                            state_d   = ST_HELD;
                        end else begin
                            cnt_d   = DBW'(1);
                            state_d = ST_PRESS_DB;
                        end
                    end else begin
                        // Idle or multi-row bounce: keep scanning.
                        col_d = col_q + 1'b1;
                    end
                end

                ST_PRESS_DB: begin
                    if (row_in == row_q) begin
                        if (cnt_inc == DB_MAX) begin
                            pressed_d = 1'b1;
                            button_d  = key_ascii(row_index(row_q), col_q);
                            cnt_d     = '0;
                            state_d   = ST_HELD;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d   = '0;
                        col_d   = col_q + 1'b1;
                        state_d = ST_SCAN;
                    end
                end

                ST_HELD: begin
                    if (row_idle) begin
                        // Release is accepted on the all-high sample after the count saturates.
                        if (cnt_q == DB_MAX) begin
                            pressed_d = 1'b0;
                            cnt_d     = '0;
                            state_d   = ST_SCAN;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        cnt_d = '0;
                    end
                end

                default: begin
                    cnt_d     = '0;
                    pressed_d = 1'b0;
                    state_d   = ST_SCAN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_SCAN;
            slot_q    <= '0;
            col_q     <= 2'd0;
            cnt_q     <= '0;
            row_q     <= 4'hF;
            pressed_q <= 1'b0;
            button_q  <= ASCII_SPACE;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            col_q     <= col_d;
            cnt_q     <= cnt_d;
            row_q     <= row_d;
            pressed_q <= pressed_d;
            button_q  <= button_d;
        end
    end

`ifdef KEYPAD_MULTIKEY_ERR_EN
    logic multi_err_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            multi_err_q <= 1'b0;
        end else begin
            multi_err_q <= sample && row_multi;
        end
    end

    assign multi_err = multi_err_q;
`else
    logic unused_multi;
    assign unused_multi = row_multi;
`endif

    assign col_out    = ~(4'b0001 << col_q);
    assign Keypressed = pressed_q;
    assign button     = button_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner (SCAN_DIV=4, DEBOUNCE_CNT=3) with a keypad model on row_in.
`timescale 1ns/1ps
module tb_keypad_scanner;

    logic       clk;
    logic       rst;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic       Keypressed;
    logic [7:0] button;
`ifdef KEYPAD_MULTIKEY_ERR_EN
    logic       multi_err;
`endif

    // Keypad model: a held key pulls its row low while its column is driven.
    logic       key_on;
    logic [1:0] key_r;
    logic [1:0] key_c;
    logic       multi_on;

    int n_pass;
    int n_total;
    int cyc;

    keypad_scanner #(
        .SCAN_DIV     (4),
        .DEBOUNCE_CNT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .row_in     (row_in),
        .col_out    (col_out),
        .Keypressed (Keypressed),
`ifdef KEYPAD_MULTIKEY_ERR_EN
        .multi_err  (multi_err),
`endif
        .button     (button)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        if (key_on && !col_out[key_c]) begin
            row_in[key_r] = 1'b0;
        end
        if (multi_on && !col_out[0]) begin
            row_in[0] = 1'b0;
            row_in[2] = 1'b0;
        end
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %h expected %h (edge %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Advance to just after rising edge n (counted from reset release).
    task automatic to_edge(input int n);
        while (cyc < n) begin
            @(posedge clk);
            cyc++;
        end
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        #1;
    endtask

    initial begin
        n_pass   = 0;
        n_total  = 0;
        cyc      = 0;
        key_on   = 1'b0;
        key_r    = 2'd0;
        key_c    = 2'd0;
        multi_on = 1'b0;
        rst      = 1'b0;
        #23;
        check("rst_col", {4'h0, col_out}, 8'h0E);
        check("rst_kp", {7'h0, Keypressed}, 8'h00);
        check("rst_btn", button, 8'h20);
        release_reset();

        // Idle scanning: column advances on every 4th edge.
        to_edge(3);  check("idle_col3", {4'h0, col_out}, 8'h0E);
        to_edge(4);  check("idle_col4", {4'h0, col_out}, 8'h0D);
        to_edge(8);  check("idle_col8", {4'h0, col_out}, 8'h0B);
        to_edge(12); check("idle_col12", {4'h0, col_out}, 8'h07);
        to_edge(16); check("idle_col16", {4'h0, col_out}, 8'h0E);
        to_edge(40);
        check("idle_col40", {4'h0, col_out}, 8'h0B);
        check("idle_kp", {7'h0, Keypressed}, 8'h00);
        check("idle_btn", button, 8'h20);

        // Press '5': detected at edge 56, accepted at edge 64.
        key_r = 2'd1; key_c = 2'd1; key_on = 1'b1;
        to_edge(56); check("p5_col_det", {4'h0, col_out}, 8'h0D);
        to_edge(60); check("p5_col_hold", {4'h0, col_out}, 8'h0D);
        to_edge(63); check("p5_kp_early", {7'h0, Keypressed}, 8'h00);
        to_edge(64);
        check("p5_kp_rise", {7'h0, Keypressed}, 8'h01);
        check("p5_btn", button, 8'h35);

        // Release '5': first all-high sample at 72, fall at 84.
        to_edge(70); key_on = 1'b0;
        to_edge(83);
        check("r5_kp_late", {7'h0, Keypressed}, 8'h01);
        check("r5_col_hold", {4'h0, col_out}, 8'h0D);
        to_edge(84);
        check("r5_kp_fall", {7'h0, Keypressed}, 8'h00);
        check("r5_btn_keep", button, 8'h35);
        to_edge(88); check("r5_col_resume", {4'h0, col_out}, 8'h0B);

        // Bounce on 'A' (row0/col3): one low sample at 96, high at 100.
        to_edge(92);
        key_r = 2'd0; key_c = 2'd3; key_on = 1'b1;
        to_edge(96); check("bnc_col_held", {4'h0, col_out}, 8'h07);
        key_on = 1'b0;
        to_edge(100);
        check("bnc_col_rot", {4'h0, col_out}, 8'h0E);
        check("bnc_kp", {7'h0, Keypressed}, 8'h00);
        check("bnc_btn", button, 8'h35);

        // Press '#' (row3/col2): detect 112, accept 120, release fall 136.
        key_r = 2'd3; key_c = 2'd2; key_on = 1'b1;
        to_edge(119); check("ph_kp_early", {7'h0, Keypressed}, 8'h00);
        to_edge(120);
        check("ph_kp_rise", {7'h0, Keypressed}, 8'h01);
        check("ph_btn", button, 8'h23);
        key_on = 1'b0;
        to_edge(135); check("rh_kp_late", {7'h0, Keypressed}, 8'h01);
        to_edge(136);
        check("rh_kp_fall", {7'h0, Keypressed}, 8'h00);
        check("rh_btn_keep", button, 8'h23);

        // Two rows low on column 0: sampled at 148 and 164, never accepted.
        to_edge(140);
        multi_on = 1'b1;
`ifdef KEYPAD_MULTIKEY_ERR_EN
        to_edge(147); check("merr_before", {7'h0, multi_err}, 8'h00);
        to_edge(148); check("merr_pulse", {7'h0, multi_err}, 8'h01);
        to_edge(149); check("merr_after", {7'h0, multi_err}, 8'h00);
        to_edge(164); check("merr_pulse2", {7'h0, multi_err}, 8'h01);
`endif
        to_edge(148);
        check("mk_col_rot", {4'h0, col_out}, 8'h0D);
        check("mk_kp", {7'h0, Keypressed}, 8'h00);
        to_edge(164);
        check("mk_col_rot2", {4'h0, col_out}, 8'h0D);
        check("mk_kp2", {7'h0, Keypressed}, 8'h00);
        check("mk_btn", button, 8'h23);
        multi_on = 1'b0;

        // Press 'D' (row3/col3): detect 176, accept 184.
        key_r = 2'd3; key_c = 2'd3; key_on = 1'b1;
        to_edge(184);
        check("pd_kp_rise", {7'h0, Keypressed}, 8'h01);
        check("pd_btn", button, 8'h44);

        // Asynchronous reset while held.
        to_edge(190);
        rst = 1'b0;
        #1;
        check("ar_kp", {7'h0, Keypressed}, 8'h00);
        check("ar_btn", button, 8'h20);
        check("ar_col", {4'h0, col_out}, 8'h0E);
        repeat (2) @(posedge clk);
        release_reset();

        // 'D' still held: detect at 16, accept at 24.
        to_edge(16); check("ra_col_det", {4'h0, col_out}, 8'h07);
        to_edge(23);
        check("ra_kp_early", {7'h0, Keypressed}, 8'h00);
        check("ra_btn_early", button, 8'h20);
        to_edge(24);
        check("ra_kp_rise", {7'h0, Keypressed}, 8'h01);
        check("ra_btn", button, 8'h44);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
